scl_stall_scheduler: RTL
========================

# scl_stall_scheduler

Round-robin scheduler that shares the single `scl_staller` between up to `NUM_REQ` requesting engines (e.g. SDR TX, DDR TX, CCC engine) in the top-level controller. Each requester posts a stall request with a 5-bit cycle count. The scheduler grants one at a time, drives the staller's flag/cycles inputs, waits for its done, runs the mandatory release handshake, and returns a per-requester done (or timeout error) pulse. A watchdog aborts a grant whose staller never reports done.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 40: cycles in STALL without `i_stall_done` before abort, 34..63.

Ports:
- `i_sch_clk`  in  1  clock.
- `i_sch_rst_n`  in  1  reset; synchronous, active-low.
- `i_req`  in  NUM_REQ  per-requester stall request, level, held until done/err.
- `i_req_cycles`  in  5*NUM_REQ  flattened counts; requester k at bits [5k+4:5k].
- `o_req_done`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `o_req_err`  out  NUM_REQ  one-cycle timeout pulse to the granted requester.
- `o_grant_id`  out  clog2(NUM_REQ), min 1  id of current/last grant.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_stall_flag`  out  1  to staller `i_stall_flag`.
- `o_stall_cycles`  out  5  to staller `i_stall_cycles`.
- `i_stall_done`  in  1  from staller `o_stall_done`.

## Operation
- States: IDLE, STALL, RELEASE. Registered Moore outputs except done/err pulses, which are registered on the transition.
- IDLE: if any `i_req` high, pick the first set bit at or after `rr_ptr` (wrap modulo NUM_REQ). Latch its id into `o_grant_id` and its cycles into `o_stall_cycles`, set `o_stall_flag`=1, clear the watchdog, then go to STALL.
- STALL: `o_stall_flag` held at 1; `o_stall_cycles` stable; watchdog increments each cycle.
  - `i_stall_done`=1: `o_stall_flag`<=0; pulse `o_req_done[grant]`; go to RELEASE.
  - Watchdog == TIMEOUT-1 without done: `o_stall_flag`<=0; pulse `o_req_err[grant]`; go to RELEASE.
  - Done and timeout in the same cycle: done wins.
- RELEASE: flag held at 0. When `i_stall_done`=0: `rr_ptr`<=grant+1 (wraps to 0 past NUM_REQ-1), go to IDLE. Stays in RELEASE while done is still high.
- Requester drops `i_req` during STALL: ignored. The grant runs to completion and the pulse is still issued.
- New or other requests during STALL/RELEASE: held pending and arbitrated in the next IDLE.
- `i_req_cycles`=0 is legal. The staller reports done on its first flagged cycle; the same sequencing applies.
- Reset values: `o_stall_flag`=0, `o_stall_cycles`=0, `o_req_done`=0, `o_req_err`=0, `o_grant_id`=0, `o_busy`=0, `rr_ptr`=0, watchdog=0, state IDLE.
- Reset mid-operation: everything returns to reset values on the next edge. No done/err pulse is issued for the aborted grant.

## Timing
- Request seen in IDLE at edge t: `o_stall_flag`=1 from t+1.
- With the staller, `o_scl_stall` is high for N cycles; `i_stall_done` rises N+1 cycles after the flag rises.
- Flag falls and `o_req_done` pulses one cycle after done is seen. Done clears one cycle later; IDLE is reached the cycle after that.
- Minimum idle gap between consecutive flag-high windows: 2 cycles. This guarantees the staller counter restarts from 0.
- Back-to-back grant: request to the second flag rise is N+5 cycles for the first requester's count N.

## Structure
- Shared package `nt_stall_pkg`:
  - state enum `{IDLE, STALL, RELEASE}`.
  - `STALL_CNT_W`=5.
  - `STALL_TO_W`=6.
- One sub-module, `rr_picker`. It is combinational: it takes `i_req` and `rr_ptr` and returns a found flag and a winner id. It is reusable by other arbiters in the design.
- The staller itself is instantiated at top level, not inside this block.

## Test plan
- Single request, req[1]=1, cycles=5 -> flag high 7 cycles; `o_scl_stall` high 5; `o_req_done[1]` one pulse; `o_grant_id`=1; back to IDLE 2 cycles after the done pulse.
- req[0], req[2], req[3] all asserted together, `rr_ptr`=0, cycles 3/4/2 -> grants in order 0, 2, 3; each done pulses exactly once; flag low ≥2 cycles between windows.
- Starvation check: req[0] held continuously, req[3] set once -> after grant 0, the next grant is 3 before 0 again.
- Cycles=0 on req[2] -> flag high 1 cycle; done pulse; no `o_scl_stall` assertion.
- Staller done forced low, TIMEOUT=40 -> flag drops after 40 cycles in STALL; `o_req_err[grant]` pulses; `o_req_done` stays 0; then arbitration resumes.
- Reset asserted mid-STALL (cycles=10, after 4 cycles) -> next edge: flag=0, busy=0, no done/err pulse; after release, a fresh request is granted from `rr_ptr`=0.

Source files
------------

// File: rtl/nt_stall_pkg.sv
// Shared definitions for the SCL stall path: scheduler state encoding and
// the widths of the stall-cycle count and watchdog.
package nt_stall_pkg;

  localparam int STALL_CNT_W = 5;
  localparam int STALL_TO_W  = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    RELEASE = 2'd2
  } stall_state_e;

endpackage

// File: rtl/scl_stall_scheduler_if.sv
// Requester and staller bundle of the stall scheduler. The slave modport is
// the scheduler's view; the master modport is the requesters plus the staller.
interface scl_stall_scheduler_if
  import nt_stall_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]             i_req;
  logic [STALL_CNT_W*NUM_REQ-1:0] i_req_cycles;
  logic [NUM_REQ-1:0]             o_req_done;
  logic [NUM_REQ-1:0]             o_req_err;
  logic [ID_W-1:0]                o_grant_id;
  logic                           o_busy;
  logic                           o_stall_flag;
  logic [STALL_CNT_W-1:0]         o_stall_cycles;
  logic                           i_stall_done;

  modport slave (
    input  i_req, i_req_cycles, i_stall_done,
    output o_req_done, o_req_err, o_grant_id, o_busy, o_stall_flag, o_stall_cycles
  );

  modport master (
    output i_req, i_req_cycles, i_stall_done,
    input  o_req_done, o_req_err, o_grant_id, o_busy, o_stall_flag, o_stall_cycles
  );

endinterface

// File: rtl/scl_stall_scheduler_rr_picker.sv
// Combinational round-robin picker: finds the first set request bit at or
// after ptr, wrapping modulo N. Reusable by any arbiter with a rotating pointer.
module rr_picker #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] id
);

  logic [ID_W:0] idx;

  // Scan offsets from farthest to nearest so the nearest hit is the last
  // assignment and therefore wins.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // one unassigned would infer a latch.
    found = 1'b0;
    id    = '0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (ID_W + 1)'(i);
      if (idx >= (ID_W + 1)'(N)) begin
        idx = idx - (ID_W + 1)'(N);
      end
      if (req[idx[ID_W-1:0]]) begin
        found = 1'b1;
        id    = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/scl_stall_scheduler.sv
// Round-robin owner of the single scl_staller: grants one requester at a time,
// runs flag/done/release sequencing and a watchdog, and returns done/err pulses.
module scl_stall_scheduler
  import nt_stall_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 40
) (
  input  logic                 i_sch_clk,
  input  logic                 i_sch_rst_n,
  scl_stall_scheduler_if.slave sch
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [STALL_TO_W-1:0] WDOG_LAST = STALL_TO_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]       LAST_ID   = ID_W'(NUM_REQ - 1);

  stall_state_e           state;
  logic [ID_W-1:0]        rr_ptr;
  logic [STALL_TO_W-1:0]  wdog;
  logic [ID_W-1:0]        grant_q;
  logic [STALL_CNT_W-1:0] cycles_q;
  logic                   flag_q;
  logic                   busy_q;
  logic [NUM_REQ-1:0]     done_q;
  logic [NUM_REQ-1:0]     err_q;

  logic                   pick_found;
  logic [ID_W-1:0]        pick_id;
  logic [ID_W-1:0]        ptr_next;
  logic [STALL_CNT_W-1:0] cyc_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cyc
    assign cyc_arr[k] = sch.i_req_cycles[STALL_CNT_W*k +: STALL_CNT_W];
  end

  rr_picker #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr_picker (
    .req   (sch.i_req),
    .ptr   (rr_ptr),
    .found (pick_found),
    .id    (pick_id)
  );

  assign ptr_next = (grant_q == LAST_ID) ? '0 : grant_q + ID_W'(1);

  always_ff @(posedge i_sch_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // read in this block sees the value from before the edge.
    if (!i_sch_rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      wdog     <= '0;
      grant_q  <= '0;
      cycles_q <= '0;
      flag_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      // Pulses default low and are raised only on the STALL exit edge.
      done_q <= '0;
      err_q  <= '0;
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            grant_q  <= pick_id;
            cycles_q <= cyc_arr[pick_id];
            flag_q   <= 1'b1;
            busy_q   <= 1'b1;
            wdog     <= '0;
            state    <= STALL;
          end
        end
        STALL: begin
          wdog <= wdog + STALL_TO_W'(1);
          if (sch.i_stall_done) begin
            flag_q          <= 1'b0;
            done_q[grant_q] <= 1'b1;
            state           <= RELEASE;
          end else if (wdog == WDOG_LAST) begin
            flag_q         <= 1'b0;
            err_q[grant_q] <= 1'b1;
            state          <= RELEASE;
          end
        end
        RELEASE: begin
          // Waiting for done to drop lets the staller counter restart from 0.
          if (!sch.i_stall_done) begin
            rr_ptr <= ptr_next;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign sch.o_req_done     = done_q;
  assign sch.o_req_err      = err_q;
  assign sch.o_grant_id     = grant_q;
  assign sch.o_busy         = busy_q;
  assign sch.o_stall_flag   = flag_q;
  assign sch.o_stall_cycles = cycles_q;

endmodule
